// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Double-buffered load with frame-boundary commit, ghost blanking and leading-zero suppression.
module disp_scan_ctrl #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_lz_blank,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [15:0] i_ld_data,
    input  logic [3:0]  i_ld_dp,
    output logic [3:0]  o_nib,
    output logic [3:0]  o_an,
    output logic        o_dp_n,
    output logic        o_frame_tick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

    logic [CntW-1:0] r_cnt;
    logic [1:0]      r_digit;
    logic [15:0]     r_disp;
    logic [3:0]      r_dp;
    logic [15:0]     r_shadow;
    logic [3:0]      r_shadow_dp;
    logic            r_pending;

    logic [3:0]      w_sup;
    logic            w_on;
    logic            w_lit;
    logic            w_frame_tick;
    logic            w_commit;
    logic            w_accept;

    always_comb begin
        w_sup[0] = 1'b0;
        w_sup[3] = i_lz_blank && (r_disp[15:12] == 4'h0);
        w_sup[2] = w_sup[3] && (r_disp[11:8] == 4'h0);
        w_sup[1] = w_sup[2] && (r_disp[7:4] == 4'h0);

        o_nib = r_disp[3:0];
        case (r_digit)
            2'd0: o_nib = r_disp[3:0];
            2'd1: o_nib = r_disp[7:4];
            2'd2: o_nib = r_disp[11:8];
            2'd3: o_nib = r_disp[15:12];
            default: o_nib = r_disp[3:0];
        endcase

        w_on         = (r_cnt >= BlankEnd);
        w_lit        = w_on && !w_sup[r_digit];
        w_frame_tick = (r_digit == 2'd3) && (r_cnt == CntMax);

        o_an         = w_lit ? ~(4'b0001 << r_digit) : 4'b1111;
        o_dp_n       = w_lit ? ~r_dp[r_digit] : 1'b1;
        o_frame_tick = w_frame_tick;
        o_ld_ready   = ~r_pending;

        // With the scan stopped there is no frame boundary to wait for.
        w_commit = r_pending && (w_frame_tick || !i_en);
        w_accept = i_ld_valid && !r_pending;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_digit     <= 2'd0;
            r_disp      <= 16'h0000;
            r_dp        <= 4'h0;
            r_shadow    <= 16'h0000;
            r_shadow_dp <= 4'h0;
            r_pending   <= 1'b0;
        end else begin
            if (!i_en) begin
                r_cnt   <= '0;
                r_digit <= 2'd0;
            end else if (r_cnt == CntMax) begin
                r_cnt   <= '0;
                r_digit <= r_digit + 2'd1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end

            if (w_commit) begin
                r_disp    <= r_shadow;
                r_dp      <= r_shadow_dp;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_shadow    <= i_ld_data;
                r_shadow_dp <= i_ld_dp;
                r_pending   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. Holds a 16-bit hex value (4 nibbles) plus decimal points. Sequences one digit at a time: presents that digit's nibble to the combinational seven-segment decoder and drives the matching anode. Double-buffered load interface with handshake; new values take effect only at frame boundaries (no tearing). Ghost-blanking interval between digits; optional leading-zero suppression.

Parameters:
PRESCALE, 1000, clock cycles per digit slot (blank phase + on phase); must exceed BLANK_CYCLES
BLANK_CYCLES, 16, cycles at start of each slot with all anodes off; must be >= 1

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous reset, active-high
en  in  1  scan enable; low = display dark, scan held at digit 0
lz_blank  in  1  1 = suppress leading-zero digits 3..1
ld_valid  in  1  load request
ld_ready  out  1  controller can accept a load
ld_data  in  16  value; [15:12]=digit 3 (leftmost) ... [3:0]=digit 0
ld_dp  in  4  decimal points, bit i = digit i, 1 = lit
nib  out  4  nibble to decoder inputs d3..d0
an  out  4  anodes, active-low, bit i = digit i
dp_n  out  1  decimal point segment, active-low
frame_tick  out  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Clock and reset: one clock (clk); rst synchronous, active-high, sampled on rising edge.
- Reset values: an=4'b1111, nib=0, dp_n=1, frame_tick=0, ld_ready=1, display reg=0, dp reg=0, shadow empty, digit index=0, slot counter cnt=0.
- Registers: display reg (16b + 4b dp) feeds the scan. Shadow reg (16b + 4b) plus pending flag. ld_ready = ~pending.
- Load: when ld_valid & ld_ready on an edge, ld_data/ld_dp go into the shadow and pending=1. ld_valid while ld_ready=0 is ignored; the source holds.
- Commit: shadow copies into the display reg and pending clears on the edge where frame_tick=1. With en=0, commit happens on the first edge after pending=1. Commit and a new accept never coincide, because ld_ready=0 while pending.
- Scan, en=1:
  - cnt counts 0..PRESCALE-1 per slot.
  - At cnt==PRESCALE-1: cnt wraps to 0; digit index advances 0->1->2->3->0.
  - frame_tick=1 exactly when digit==3 and cnt==PRESCALE-1.
- Phases, as a function of current registered cnt/digit:
  - BLANK (cnt<BLANK_CYCLES): an=4'b1111, dp_n=1, nib=display nibble of current digit.
  - ON (cnt>=BLANK_CYCLES): an=~(1<<digit), unless the digit is suppressed; dp_n=~dp[digit].
- Leading-zero suppression: when lz_blank=1, digit i (i=3,2,1) is suppressed if nibbles 3..i are all zero. Digit 0 is never suppressed. A suppressed digit keeps an=4'b1111 and dp_n=1 for the whole slot. lz_blank is evaluated live.
- en=0: on the next edge cnt=0, digit=0, an=4'b1111, dp_n=1, frame_tick=0. Scan restarts from digit 0 BLANK when en returns high.
- Latency: a load accepted mid-frame first appears in the digit 0 slot of the following frame (cnt=0 after frame_tick). Worst case is one full frame plus 1 cycle.
- Reset mid-frame: returns everything to reset values on that edge and discards any pending shadow.
- Width: cnt is clog2(PRESCALE) bits; digit index is 2 bits and wraps naturally.

Test Plan:
(All with PRESCALE=8, BLANK_CYCLES=2.)
- Reset then en=1, load 16'h1234, dp=0 -> ld_ready drops 1 cycle after accept. Commit at first frame_tick. Next frame:
  - digit 0 ON cycles show an=1110, nib=4;
  - then an=1101/nib=3, an=1011/nib=2, an=0111/nib=1;
  - each slot has 2 cycles with an=1111;
  - frame_tick every 32 cycles.
- Load 16'h00A0 with lz_blank=1 -> digits 3 and 2 keep an=1111 all slot. Digit 1 shows nib=A; digit 0 shows nib=0.
- Load 16'h0000, lz_blank=1 -> only digit 0 lit, nib=0.
- Load 16'hBEEF while 16'h1234 is displaying, at digit 1 cnt=5 -> rest of frame still shows 1234. A second ld_valid during pending gets no accept. BEEF appears from next digit 0 slot; ld_ready returns to 1 after commit.
- dp=4'b0100 -> dp_n=0 only during digit 2 ON cycles.
- en=0 mid-frame at digit 2 -> an=1111 next cycle. A pending load commits on the following edge. en=1 restarts at digit 0 cnt=0.
- rst asserted at digit 3 cnt=6 with pending shadow -> all outputs at reset values next cycle; display=0; ld_ready=1.
